// File: rtl/pending_encoder_16to4.sv
// Sticky pending-request register drained lowest-index-first through a
// registered valid/ready output slot carrying the 4-bit binary index.
module pending_encoder_16to4 #(
   parameter int unsigned N = 16,
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         enable,
   input  logic         clear,
   input  logic [N-1:0] in_req,
   output logic [W-1:0] out_idx,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] pending,
   output logic         overflow
);

   logic [N-1:0] pending_q, pending_d;
   logic [W-1:0] idx_q, idx_d;
   logic         valid_q, valid_d;
   logic         overflow_q, overflow_d;

   logic [W-1:0] enc;
   logic         found;
   logic         slot_free;
   logic         issue;
   logic [N-1:0] issue_mask;
   logic [N-1:0] req_eff;

   // Lowest set bit of the registered pending vector; bit 0 wins.
   always_comb begin
      enc   = '0;
      found = 1'b0;
      for (int i = 0; i < int'(N); i++) begin
         if (!found && pending_q[i]) begin
            enc   = W'(i);
            found = 1'b1;
         end
      end
   end

   always_comb begin
      slot_free  = !valid_q || out_ready;
      issue      = slot_free && found;
      issue_mask = issue ? (N'(1) << enc) : '0;
      req_eff    = enable ? in_req : '0;

      pending_d  = pending_q;
      idx_d      = idx_q;
      valid_d    = valid_q;
      overflow_d = overflow_q;

      if (clear) begin
         pending_d  = '0;
         valid_d    = 1'b0;
         overflow_d = 1'b0;
      end else begin
         // A new request on the bit being issued re-arms it rather than overflowing.
         pending_d  = (pending_q & ~issue_mask) | req_eff;
         overflow_d = overflow_q | (|(req_eff & pending_q & ~issue_mask));
         if (slot_free) begin
            valid_d = found;
         end
         if (issue) begin
            idx_d = enc;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending_q  <= '0;
         idx_q      <= '0;
         valid_q    <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         pending_q  <= pending_d;
         idx_q      <= idx_d;
         valid_q    <= valid_d;
         overflow_q <= overflow_d;
      end
   end

   assign pending   = pending_q;
   assign out_idx   = idx_q;
   assign out_valid = valid_q;
   assign overflow  = overflow_q;

endmodule
